// File: rtl/tmo_scheduler_pkg.sv
// ============================================================================
// Module   : tmo_scheduler_pkg
// Brief    : Shared unit/state encodings and tick selection for tmo_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tmo_scheduler_pkg;

  localparam logic [1:0] UNIT_US = 2'd0;
  localparam logic [1:0] UNIT_MS = 2'd1;
  localparam logic [1:0] UNIT_S  = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Unit code 3 is an alias of the millisecond tick.
  function automatic logic sel_tick(input logic [1:0] unit,
                                    input logic       us,
                                    input logic       ms,
                                    input logic       s);
    logic t;
    case (unit)
      UNIT_US: t = us;
      UNIT_S:  t = s;
      default: t = ms;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmo_channel.sv
// ============================================================================
// Module   : tmo_channel
// Brief    : One-shot timeout channel: down-counter on a selected tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmo_channel
  import tmo_scheduler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic [1:0]       i_load_unit,
  input  logic             i_stop,
  input  logic             i_tick_us,
  input  logic             i_tick_ms,
  input  logic             i_tick_s,
  output logic             o_busy,
  output logic             o_expire
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_unit;
  logic             r_busy;
  logic             r_expire;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_unit_nxt;
  logic             w_expire_nxt;
  logic             w_tick;

  assign w_tick = sel_tick(r_unit, i_tick_us, i_tick_ms, i_tick_s);

  // Priority START > STOP > tick; a zero-length arm expires immediately.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_unit_nxt   = r_unit;
    w_expire_nxt = 1'b0;
    if (i_start) begin
      if (i_load_val != '0) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = i_load_val;
        w_unit_nxt  = i_load_unit;
      end else begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = '0;
        w_expire_nxt = 1'b1;
      end
    end else if (r_state == ST_RUN) begin
      if (i_stop) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else if (w_tick) begin
        if (r_cnt == c_one) begin
          w_state_nxt  = ST_IDLE;
          w_cnt_nxt    = '0;
          w_expire_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - c_one;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_unit   <= UNIT_US;
      r_busy   <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_unit   <= w_unit_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
      r_expire <= w_expire_nxt;
    end
  end

  assign o_busy   = r_busy;
  assign o_expire = r_expire;

endmodule

`default_nettype wire

// File: rtl/tmo_scheduler.sv
// ============================================================================
// Module   : tmo_scheduler
// Brief    : Multi-channel one-shot timeout scheduler driven by timer ticks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmo_scheduler
  import tmo_scheduler_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TIM_1US,
  input  logic             TIM_1MS,
  input  logic             TIM_1S,
  input  logic             START,
  input  logic [2:0]       LOAD_CH,
  input  logic [CNT_W-1:0] LOAD_VAL,
  input  logic [1:0]       LOAD_UNIT,
  input  logic [NCH-1:0]   STOP,
  output logic [NCH-1:0]   BUSY,
  output logic [NCH-1:0]   EXPIRE
);

  logic [NCH-1:0] w_start;

  // Indices at or above NCH match no channel and are therefore ignored.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_start[i] = START && (LOAD_CH == 3'(i));

    tmo_channel #(
      .CNT_W (CNT_W)
    ) u_chan (
      .CLK         (CLK),
      .RST         (RST),
      .i_start     (w_start[i]),
      .i_load_val  (LOAD_VAL),
      .i_load_unit (LOAD_UNIT),
      .i_stop      (STOP[i]),
      .i_tick_us   (TIM_1US),
      .i_tick_ms   (TIM_1MS),
      .i_tick_s    (TIM_1S),
      .o_busy      (BUSY[i]),
      .o_expire    (EXPIRE[i])
    );
  end

endmodule

`default_nettype wire
